muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 iCLK  input  1  sole clock; all state changes on rising edge.
REQ-003 iRST  input  1  reset, synchronous, active-high.
REQ-004 iStart  input  1  request strobe; sampled on each rising edge.
REQ-005 iOp  input  5  operation code from Parametros.v: OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU.
REQ-006 iA  input  32  operand rs1, signed or unsigned per iOp.
REQ-007 iB  input  32  operand rs2, signed or unsigned per iOp.
REQ-008 oBusy  output  1  high while an accepted operation is in progress.
REQ-009 oDone  output  1  single-cycle pulse; oResult valid in that cycle.
REQ-010 oResult  output  32  result register.

Function
REQ-011 The unit SHALL accept a request at a rising edge where iStart=1, oBusy=0, iRST=0 and iOp is one of the eight codes in REQ-005.
REQ-012 iStart with oBusy=1, or with any other iOp, SHALL be ignored with no state change.
REQ-013 On acceptance the unit SHALL latch iOp, iA and iB, and store operand magnitudes and result signs; later changes on iA/iB/iOp SHALL have no effect.
REQ-014 States SHALL be IDLE -> CALC -> FIX -> DONE -> IDLE; oBusy=1 in CALC and FIX only.
REQ-015 CALC SHALL last exactly 32 cycles at one bit per cycle: shift-add for multiply (64-bit product), restoring shift-subtract for divide (quotient and remainder).
REQ-016 FIX SHALL last one cycle, applying sign correction and selecting low product word (MUL), high word (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-017 DONE SHALL last one cycle with oDone=1 and then return to IDLE.
REQ-018 Latency: with acceptance at edge 0, oDone SHALL be high in the cycle after edge 33.
REQ-019 Signedness: MULH signed x signed; MULHSU signed iA x unsigned iB; MULHU, DIVU and REMU unsigned; DIV and REM signed, truncating toward zero; remainder sign SHALL equal dividend sign.
REQ-020 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return iA unchanged; latency per REQ-018.
REQ-021 Signed overflow (iA=0x80000000, iB=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0x00000000.
REQ-022 oResult SHALL hold its last value from DONE until the next FIX writes it.
REQ-023 A request arriving in the DONE cycle SHALL be accepted (oBusy=0), so oDone and acceptance coincide.

Reset
REQ-024 iRST=1 at a rising edge SHALL force IDLE, oBusy=0, oDone=0, oResult=0x00000000 and clear all internal registers.
REQ-025 iRST asserted mid-operation SHALL abort the operation, with no oDone pulse for it.
REQ-026 iRST SHALL take priority over a simultaneous iStart.

Configuration
REQ-027 Macro MULDIV_FASTMUL_EN, when defined, SHALL route the four multiply ops through a single-cycle combinational 64-bit product: acceptance -> FIX -> DONE, so oDone is high after edge 1.
REQ-028 When MULDIV_FASTMUL_EN is undefined, multiply ops SHALL use the iterative CALC path with latency per REQ-018, and no 32x32 multiplier SHALL be inferred.
REQ-029 Divide ops SHALL use the iterative path and the REQ-018 latency regardless of the macro.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD -> oResult 0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; each oDone after edge 33.
REQ-032 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-033 iStart with DIV 9/3 at edge 5 of a running op -> ignored; new request in the DONE cycle -> accepted, oBusy=1 next cycle, second result 3 after edge 33 of its own.
REQ-034 iRST at edge 10 of a DIV -> oBusy=0, oResult=0, no oDone in the following 40 cycles.
REQ-035 MUL 3 x 4 with MULDIV_FASTMUL_EN defined -> 12, oDone after edge 1; without the macro -> 12, oDone after edge 33.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: a start strobe with opcode and
// operands toward the unit, busy/done/result back from it.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic [4:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oResult;

  modport master (output iStart, iOp, iA, iB, input  oBusy, oDone, oResult);
  modport slave  (input  iStart, iOp, iA, iB, output oBusy, oDone, oResult);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit RISC-V M-extension multiply/divide unit.
// Sequence IDLE -> CALC (32 cycles, one bit per cycle) -> FIX -> DONE.
// Multiply is unsigned shift-add on operand magnitudes, divide is restoring
// shift-subtract; signs are reapplied in FIX.
// Optional macro MULDIV_FASTMUL_EN: multiply ops skip CALC and load a
// single-cycle combinational 64-bit product straight into FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         iCLK,
  input  logic         iRST,
  muldiv_unit_if.slave bus
);

  localparam logic [4:0] OPMUL    = 5'h10;
  localparam logic [4:0] OPMULH   = 5'h11;
  localparam logic [4:0] OPMULHSU = 5'h12;
  localparam logic [4:0] OPMULHU  = 5'h13;
  localparam logic [4:0] OPDIV    = 5'h14;
  localparam logic [4:0] OPDIVU   = 5'h15;
  localparam logic [4:0] OPREM    = 5'h16;
  localparam logic [4:0] OPREMU   = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] bmag_q, bmag_d;     // multiplicand / divisor magnitude
  logic [63:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, quotient}
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;       // product / quotient needs negation
  logic        negr_q, negr_d;     // remainder needs negation
  logic        bzero_q, bzero_d;
  logic [31:0] araw_q, araw_d;     // original dividend, returned by REM x/0
  logic [31:0] result_q, result_d;

  // Request decode
  logic        op_valid, a_signed, b_signed, a_sgn, b_sgn, accept, calc_mul;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    op_valid = (bus.iOp >= OPMUL) && (bus.iOp <= OPREMU);
    a_signed = (bus.iOp == OPMULH) || (bus.iOp == OPMULHSU) ||
               (bus.iOp == OPDIV)  || (bus.iOp == OPREM);
    b_signed = (bus.iOp == OPMULH) || (bus.iOp == OPDIV) || (bus.iOp == OPREM);
    a_sgn    = a_signed && bus.iA[31];
    b_sgn    = b_signed && bus.iB[31];
    a_mag    = a_sgn ? (32'd0 - bus.iA) : bus.iA;
    b_mag    = b_sgn ? (32'd0 - bus.iB) : bus.iB;
    // A new request can land in the DONE cycle since the unit is not busy there.
    accept   = bus.iStart && op_valid && ((state_q == S_IDLE) || (state_q == S_DONE));
    calc_mul = (op_q <= OPMULHU);
  end

`ifdef MULDIV_FASTMUL_EN
  logic        is_mul_in;
  logic [63:0] fast_prod;
  // Single-cycle product of the magnitudes for the fast multiply path
  always_comb begin
    is_mul_in = (bus.iOp >= OPMUL) && (bus.iOp <= OPMULHU);
    fast_prod = {32'd0, a_mag} * {32'd0, b_mag};
  end
`endif

  // One iteration of each datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bmag_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    div_sh   = acc_q[63:31];
    div_ge   = div_sh >= {1'b0, bmag_q};
    // Remainder stays below the divisor, so the difference fits 32 bits.
    div_diff = div_sh[31:0] - bmag_q;
    div_next = {(div_ge ? div_diff : div_sh[31:0]), acc_q[30:0], div_ge};
  end

  // Sign correction and word select applied in FIX
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, fix_res;

  always_comb begin
    prod_s = neg_q  ? (64'd0 - acc_q) : acc_q;
    quo_s  = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    rem_s  = negr_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    case (op_q)
      OPMUL:                     fix_res = acc_q[31:0];
      OPMULH, OPMULHSU, OPMULHU: fix_res = prod_s[63:32];
      OPDIV, OPDIVU:             fix_res = bzero_q ? 32'hFFFF_FFFF : quo_s;
      default:                   fix_res = bzero_q ? araw_q : rem_s;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    bmag_d   = bmag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    bzero_d  = bzero_q;
    araw_d   = araw_q;
    result_d = result_q;
    case (state_q)
      S_CALC: begin
        acc_d = calc_mul ? mul_next : div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      op_d    = bus.iOp;
      bmag_d  = b_mag;
      acc_d   = {32'd0, a_mag};
      cnt_d   = 5'd0;
      bzero_d = (bus.iB == 32'd0);
      neg_d   = (a_sgn ^ b_sgn) && (bus.iB != 32'd0);
      negr_d  = a_sgn;
      araw_d  = bus.iA;
      state_d = S_CALC;
`ifdef MULDIV_FASTMUL_EN
      if (is_mul_in) begin
        acc_d   = fast_prod;
        state_d = S_FIX;
      end
`endif
    end
  end

  // State register with synchronous reset clearing everything
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      op_q     <= 5'd0;
      bmag_q   <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      bzero_q  <= 1'b0;
      araw_q   <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      bmag_q   <= bmag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      bzero_q  <= bzero_d;
      araw_q   <= araw_d;
      result_q <= result_d;
    end
  end

  assign bus.oBusy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.oDone   = (state_q == S_DONE);
  assign bus.oResult = result_q;

endmodule
